// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave): one valid/ready handshake each way.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Slow data-memory model: accepts one load/store at a time and answers after
// LATENCY cycles, so the pipeline's stall logic has something to wait on.
module dmem_responder #(
  parameter int WORDS_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_nextState;
  logic [3:0]  r_cnt, w_nextCnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_srcWe;
  logic [31:0]           w_srcAddr;
  logic [31:0]           w_srcWdata;
  logic [3:0]            w_srcStrb;
  logic [WORDS_LOG2-1:0] w_idx;
  logic                  w_err;
  logic                  w_commit;

  // With LATENCY==1 the commit edge is the accept edge, so use the live bus.
  assign w_srcWe    = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_srcAddr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_srcWdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
  assign w_srcStrb  = (r_state == S_IDLE) ? bus.req_strb  : r_strb;

  assign w_idx    = w_srcAddr[WORDS_LOG2+1:2];
  assign w_err    = (|w_srcAddr[1:0]) | (|w_srcAddr[31:WORDS_LOG2+2]);
  assign w_commit = (r_state != S_RESP) && (w_nextState == S_RESP);

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            w_nextState = S_RESP;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_nextState = S_RESP;
          w_nextCnt   = 4'd0;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_strb  <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_strb  <= bus.req_strb;
      end
      if (w_commit) begin
        r_rdata <= (w_srcWe || w_err) ? 32'd0 : r_mem[w_idx];
        r_err   <= w_err;
      end
    end
  end

  // Storage is deliberately not reset; a request cut off by reset never writes.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_commit && w_srcWe && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_srcStrb[i]) r_mem[w_idx][8*i +: 8] <= w_srcWdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed and random loads/stores checked
// against a word-array model, plus accept-rate checks at LATENCY 1 and 15.
module tb_dmem_responder;

  localparam int WORDS_LOG2 = 10;
  localparam int LAT        = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCyc;
    logic        isStore;
    int          idx;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  logic tputResetN;
  int   cyc = 0;

  int checks = 0;
  int passes = 0;

  exp_t        expQ[$];
  exp_t        curExp;
  logic [31:0] modelMem [int];
  bit          inResp = 1'b0;
  bit          expectIdle = 1'b0;

  dmem_responder_if bus();
  dmem_responder_if tput1();
  dmem_responder_if tput15();

  dmem_responder #(.WORDS_LOG2(WORDS_LOG2), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset_n(resetN), .bus(bus)
  );
  dmem_responder #(.WORDS_LOG2(WORDS_LOG2), .LATENCY(1)) dutLat1 (
    .i_clk(clk), .i_reset_n(tputResetN), .bus(tput1)
  );
  dmem_responder #(.WORDS_LOG2(WORDS_LOG2), .LATENCY(15)) dutLat15 (
    .i_clk(clk), .i_reset_n(tputResetN), .bus(tput15)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic modelErr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd4 << WORDS_LOG2));
  endfunction

  // Monitor: pops one expectation per response, then watches the hold phase.
  always @(negedge clk) begin
    if (!resetN) begin
      inResp     = 1'b0;
      expectIdle = 1'b0;
    end else begin
      if (expectIdle) begin
        checkOutput("idleAfterResp", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        expectIdle = 1'b0;
      end
      if (bus.resp_valid) begin
        if (!inResp) begin
          checkOutput("respQueueDepth", 32'(expQ.size()), 32'd1);
          if (expQ.size() > 0) begin
            curExp = expQ.pop_front();
            checkOutput("respRdata", bus.resp_rdata, curExp.rdata);
            checkOutput("respErr", {31'd0, bus.resp_err}, {31'd0, curExp.err});
            checkOutput("respLatency", 32'(cyc - curExp.acceptCyc), 32'(LAT));
            if (curExp.isStore && !curExp.err) begin
              for (int i = 0; i < 4; i++)
                if (curExp.strb[i]) modelMem[curExp.idx][8*i +: 8] = curExp.wdata[8*i +: 8];
            end
          end
          inResp = 1'b1;
        end else begin
          checkOutput("holdRdata", bus.resp_rdata, curExp.rdata);
          checkOutput("holdErr", {31'd0, bus.resp_err}, {31'd0, curExp.err});
          checkOutput("reqReadyInResp", {31'd0, bus.req_ready}, 32'd0);
        end
        if (bus.resp_ready) begin
          inResp     = 1'b0;
          expectIdle = 1'b1;
        end
      end
    end
  end

  int  t1Prev = -1, t1Count = 0, t15Prev = -1, t15Count = 0;
  bit  t1Done = 1'b0, t15Done = 1'b0;

  // Throughput: with req_valid and resp_ready tied high, accepts are LATENCY+1 apart.
  always @(negedge clk) begin
    if (tputResetN && !t1Done && tput1.req_valid && tput1.req_ready) begin
      if (t1Prev >= 0) checkOutput("tputLat1Spacing", 32'(cyc - t1Prev), 32'd2);
      t1Prev = cyc;
      t1Count++;
      if (t1Count == 8) t1Done = 1'b1;
    end
    if (tputResetN && !t15Done && tput15.req_valid && tput15.req_ready) begin
      if (t15Prev >= 0) checkOutput("tputLat15Spacing", 32'(cyc - t15Prev), 32'd16);
      t15Prev = cyc;
      t15Count++;
      if (t15Count == 8) t15Done = 1'b1;
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int holdCycles, input bit waitResp,
                               output logic [31:0] rdata, output logic err);
    exp_t e;
    int   t;
    rdata = 32'hx;
    err   = 1'bx;
    @(posedge clk);
    #1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      checkOutput("acceptTimeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    e.err       = modelErr(addr);
    e.isStore   = we;
    e.idx       = int'(addr >> 2);
    e.wdata     = wdata;
    e.strb      = strb;
    e.acceptCyc = cyc;
    e.rdata     = (we || e.err) ? 32'd0 : modelMem[e.idx];
    expQ.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_strb  = 4'($urandom);
    if (!waitResp) return;
    t = 0;
    @(negedge clk);
    while (!bus.resp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.resp_valid) begin
      checkOutput("respTimeout", 32'd1, 32'd0);
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    repeat (holdCycles) @(posedge clk);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        e;
  logic [31:0] oldVal;
  logic [31:0] word0;

  initial begin
    resetN           = 1'b0;
    tputResetN       = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_strb     = 4'd0;
    bus.resp_ready   = 1'b0;
    tput1.req_valid  = 1'b1;
    tput1.req_we     = 1'b1;
    tput1.req_addr   = 32'd0;
    tput1.req_wdata  = 32'd0;
    tput1.req_strb   = 4'hF;
    tput1.resp_ready = 1'b1;
    tput15.req_valid  = 1'b1;
    tput15.req_we     = 1'b1;
    tput15.req_addr   = 32'd0;
    tput15.req_wdata  = 32'd0;
    tput15.req_strb   = 4'hF;
    tput15.resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("resetRespValid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("resetRdata", bus.resp_rdata, 32'd0);
    checkOutput("resetErr", {31'd0, bus.resp_err}, 32'd0);
    @(posedge clk);
    #1;
    resetN     = 1'b1;
    tputResetN = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b1, r, e);

    // A store cut off by reset in WAIT must leave the old word in place.
    oldVal = modelMem[4];
    applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 1'b0, r, e);
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("respValidInReset", {31'd0, bus.resp_valid}, 32'd0);
    expQ.delete();
    @(posedge clk);
    #1 resetN = 1'b1;
    applyStimulus(1'b0, 32'h10, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("loadAfterAbort", r, oldVal);

    applyStimulus(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 1'b1, r, e);
    checkOutput("storeRdataZero", r, 32'd0);
    applyStimulus(1'b0, 32'h04, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("loadDeadbeef", r, 32'hDEADBEEF);
    checkOutput("loadDeadbeefErr", {31'd0, e}, 32'd0);

    applyStimulus(1'b1, 32'h04, 32'h000000AA, 4'b0001, 0, 1'b1, r, e);
    applyStimulus(1'b0, 32'h04, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("loadByteLane", r, 32'hDEADBEAA);

    applyStimulus(1'b0, 32'h04, 32'd0, 4'd0, 5, 1'b1, r, e);
    checkOutput("loadBackpressure", r, 32'hDEADBEAA);

    applyStimulus(1'b0, 32'h06, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("misalignedErr", {31'd0, e}, 32'd1);
    checkOutput("misalignedRdata", r, 32'd0);
    word0 = modelMem[0];
    applyStimulus(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1'b1, r, e);
    checkOutput("outOfRangeErr", {31'd0, e}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("word0Unchanged", r, word0);

    oldVal = modelMem[2];
    applyStimulus(1'b1, 32'h08, 32'h12345678, 4'd0, 0, 1'b1, r, e);
    checkOutput("zeroStrbErr", {31'd0, e}, 32'd0);
    applyStimulus(1'b0, 32'h08, 32'd0, 4'd0, 0, 1'b1, r, e);
    checkOutput("zeroStrbUnchanged", r, oldVal);

    for (int n = 0; n < 40; n++) begin
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
      else               a = 32'($urandom_range(0, 15) * 4);
      applyStimulus(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b1, r, e);
    end

    for (int t = 0; t < 500 && !(t1Done && t15Done); t++) @(negedge clk);
    checkOutput("tputDone", {30'd0, t1Done, t15Done}, 32'd3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
